// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control: decodes the ID-stage opcode, carries EX/MEM/WB control bundles
// through ID/EX, EX/MEM, MEM/WB and handles load-use stalls and flushes. Option: CTRL_PERF_CNT_EN.
module pipe_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    idex_rt,
  input  logic                flush,
  output logic                Jump,
  output logic                illegal,
  output logic [3:0]          idex_ex,
  output logic [2:0]          idex_mem,
  output logic [1:0]          idex_wb,
  output logic [2:0]          exmem_mem,
  output logic [1:0]          exmem_wb,
  output logic [1:0]          memwb_wb,
  output logic                pc_write,
  output logic                ifid_write
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
`endif
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ADDIU = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);

  typedef struct packed {
    logic [3:0] ex;   // {RegDst, ALUOp[1:0], ALUSrc}
    logic [2:0] mem;  // {Branch, MemRead, MemWrite}
    logic [1:0] wb;   // {RegWrite, MemtoReg}
  } ctrl_t;

  ctrl_t dec;
  logic  dec_jump;
  logic  legal;
  logic  hazard;
  logic  stall;
  logic  bubble;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    dec      = '0;
    dec_jump = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE: dec = '{ex: 4'b1100, mem: 3'b000, wb: 2'b10};
      OP_LW:    dec = '{ex: 4'b0001, mem: 3'b010, wb: 2'b11};
      OP_SW:    dec = '{ex: 4'b0001, mem: 3'b001, wb: 2'b00};
      OP_BEQ:   dec = '{ex: 4'b0010, mem: 3'b100, wb: 2'b00};
      OP_ADDI,
      OP_ADDIU: dec = '{ex: 4'b0001, mem: 3'b000, wb: 2'b10};
      OP_J:     dec_jump = 1'b1;
      OP_JAL: begin
        dec      = '{ex: 4'b0000, mem: 3'b000, wb: 2'b10};
        dec_jump = 1'b1;
      end
      default:  legal = 1'b0;
    endcase
  end

  // A load sitting in ID/EX whose destination feeds the ID instruction needs one bubble.
  assign hazard = idex_mem[1] & (idex_rt != '0) & id_valid
                & ((idex_rt == id_rs) | (idex_rt == id_rt));
  assign stall  = hazard & ~flush;
  assign bubble = flush | hazard | ~id_valid;

  assign Jump       = dec_jump & id_valid & ~flush;
  assign illegal    = id_valid & ~legal;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ex   <= '0;
      idex_mem  <= '0;
      idex_wb   <= '0;
      exmem_mem <= '0;
      exmem_wb  <= '0;
      memwb_wb  <= '0;
    end else begin
      if (bubble) begin
        idex_ex  <= '0;
        idex_mem <= '0;
        idex_wb  <= '0;
      end else begin
        idex_ex  <= dec.ex;
        idex_mem <= dec.mem;
        idex_wb  <= dec.wb;
      end
      exmem_mem <= idex_mem;
      exmem_wb  <= idex_wb;
      memwb_wb  <= exmem_wb;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: a driver pushes expected responses from a
// table-driven pipeline model, a monitor pops and compares each cycle.
module tb_pipe_control_unit;

  localparam int OPW = 6;
  localparam int RW  = 5;
`ifdef CTRL_PERF_CNT_EN
  localparam int CW  = 2;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [OPW-1:0] opcode;
  logic           id_valid;
  logic [RW-1:0]  id_rs, id_rt, idex_rt;
  logic           flush;
  logic           Jump, illegal, pc_write, ifid_write;
  logic [3:0]     idex_ex;
  logic [2:0]     idex_mem, exmem_mem;
  logic [1:0]     idex_wb, exmem_wb, memwb_wb;
`ifdef CTRL_PERF_CNT_EN
  logic [CW-1:0]  stall_cnt, flush_cnt;
`endif

  pipe_control_unit #(
    .OPCODE_W(OPW),
    .REG_W(RW)
`ifdef CTRL_PERF_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .idex_rt(idex_rt), .flush(flush),
    .Jump(Jump), .illegal(illegal),
    .idex_ex(idex_ex), .idex_mem(idex_mem), .idex_wb(idex_wb),
    .exmem_mem(exmem_mem), .exmem_wb(exmem_wb), .memwb_wb(memwb_wb),
    .pc_write(pc_write), .ifid_write(ifid_write)
`ifdef CTRL_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       jump, ill, pcw;
    logic [3:0] ex;
    logic [2:0] mem, xm_mem;
    logic [1:0] wb, xm_wb, mw_wb;
    int         scnt, fcnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference pipeline state: one control record per stage.
  logic [3:0] m_ex;
  logic [2:0] m_mem, m_xm_mem;
  logic [1:0] m_wb, m_xm_wb, m_mw_wb;
  int         m_scnt, m_fcnt, cnt_max;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {legal, ex[3:0], mem[2:0], wb[1:0], jump}
  function automatic logic [10:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b000000: return 11'b1_1100_000_10_0;
      6'b100011: return 11'b1_0001_010_11_0;
      6'b101011: return 11'b1_0001_001_00_0;
      6'b000100: return 11'b1_0010_100_00_0;
      6'b001000: return 11'b1_0001_000_10_0;
      6'b001001: return 11'b1_0001_000_10_0;
      6'b000010: return 11'b1_0000_000_00_1;
      6'b000011: return 11'b1_0000_000_10_1;
      default:   return 11'b0_0000_000_00_0;
    endcase
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_xm_mem = '0; m_xm_wb = '0; m_mw_wb = '0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  // Drive one ID-stage slot at the falling edge and queue what the DUT must show.
  task automatic drive_cycle(input logic [5:0] op, input logic v, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] irt, input logic fl);
    logic [10:0] d;
    logic        load_in_ex, uses, haz, stl;
    exp_t        e;
    @(negedge clk);
    opcode = op; id_valid = v; id_rs = rs; id_rt = rt; idex_rt = irt; flush = fl;
    d          = ref_decode(op);
    load_in_ex = m_mem[1];
    uses       = (irt == rs) || (irt == rt);
    haz        = load_in_ex && irt != 0 && v && uses;
    stl        = haz && !fl;
    e.jump = d[0] && v && !fl;
    e.ill  = v && !d[10];
    e.pcw  = !stl;
    m_mw_wb  = m_xm_wb;
    m_xm_wb  = m_wb;
    m_xm_mem = m_mem;
    if (fl || haz || !v) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else begin
      m_ex = d[9:6]; m_mem = d[5:3]; m_wb = d[2:1];
    end
    if (stl && m_scnt < cnt_max) m_scnt++;
    if (fl && m_fcnt < cnt_max) m_fcnt++;
    e.ex = m_ex; e.mem = m_mem; e.wb = m_wb;
    e.xm_mem = m_xm_mem; e.xm_wb = m_xm_wb; e.mw_wb = m_mw_wb;
    e.scnt = m_scnt; e.fcnt = m_fcnt;
    q.push_back(e);
  endtask

  task automatic wait_drained();
    int n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("scoreboard_drain", q.size(), 0);
    @(posedge clk);
    #2;
  endtask

  // Monitor: combinational outputs just before the edge, registered outputs just after.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("Jump", Jump, e.jump);
        check("illegal", illegal, e.ill);
        check("pc_write", pc_write, e.pcw);
        check("ifid_write", ifid_write, e.pcw);
        @(posedge clk);
        #1;
        check("idex_ex", idex_ex, e.ex);
        check("idex_mem", idex_mem, e.mem);
        check("idex_wb", idex_wb, e.wb);
        check("exmem_mem", exmem_mem, e.xm_mem);
        check("exmem_wb", exmem_wb, e.xm_wb);
        check("memwb_wb", memwb_wb, e.mw_wb);
`ifdef CTRL_PERF_CNT_EN
        check("stall_cnt", stall_cnt, e.scnt);
        check("flush_cnt", flush_cnt, e.fcnt);
`endif
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idex_ex"}, idex_ex, 0);
    check({tag, "_idex_mem"}, idex_mem, 0);
    check({tag, "_idex_wb"}, idex_wb, 0);
    check({tag, "_exmem_mem"}, exmem_mem, 0);
    check({tag, "_exmem_wb"}, exmem_wb, 0);
    check({tag, "_memwb_wb"}, memwb_wb, 0);
    check({tag, "_pc_write"}, pc_write, 1);
    check({tag, "_ifid_write"}, ifid_write, 1);
`ifdef CTRL_PERF_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, 0);
    check({tag, "_flush_cnt"}, flush_cnt, 0);
`endif
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         ADDI = 6'b001000, ADDIU = 6'b001001, J = 6'b000010, JAL = 6'b000011;

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{R, LW, SW, BEQ, ADDI, ADDIU, J, JAL};
`ifdef CTRL_PERF_CNT_EN
    cnt_max = (1 << CW) - 1;
`else
    cnt_max = 65535;
`endif
    rst_n = 1'b0; opcode = '0; id_valid = 1'b0; id_rs = '0; id_rt = '0; idex_rt = '0; flush = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // R-type flows through all three control registers.
    drive_cycle(R, 1, 1, 2, 0, 0);
    repeat (3) drive_cycle(R, 0, 0, 0, 0, 0);

    // lw then dependent use: one stall, then the use is captured.
    drive_cycle(LW, 1, 1, 5, 0, 0);
    drive_cycle(ADDI, 1, 5, 7, 5, 0);
    drive_cycle(ADDI, 1, 5, 7, 5, 0);
    // Same pair with idex_rt = 0: no stall.
    drive_cycle(LW, 1, 0, 0, 0, 0);
    drive_cycle(ADDI, 1, 0, 7, 0, 0);
    // Same pair with flush in the hazard cycle: bubble, no stall, no jump.
    drive_cycle(LW, 1, 1, 5, 0, 0);
    drive_cycle(J, 1, 5, 7, 5, 1);
    // Opcode sweep, ending with an unlisted opcode.
    drive_cycle(J, 1, 0, 0, 0, 0);
    drive_cycle(JAL, 1, 0, 0, 0, 0);
    drive_cycle(BEQ, 1, 1, 2, 0, 0);
    drive_cycle(ADDIU, 1, 1, 2, 0, 0);
    drive_cycle(SW, 1, 1, 2, 0, 0);
    drive_cycle(6'b111111, 1, 1, 2, 0, 0);
    repeat (3) drive_cycle(6'b111111, 0, 0, 0, 0, 0);

    // Randomized traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) != 0) op = ops[$urandom_range(7)];
      else                        op = 6'($urandom);
      drive_cycle(op, ($urandom_range(7) != 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  5'($urandom_range(3)), ($urandom_range(7) == 0));
    end

    // Asynchronous reset while a stall is being asserted.
    drive_cycle(LW, 1, 1, 6, 0, 0);
    wait_drained();
    @(negedge clk);
    opcode = R; id_valid = 1'b1; id_rs = 5'd6; id_rt = 5'd1; idex_rt = 5'd6; flush = 1'b0;
    #1;
    check("midstall_pc_write", pc_write, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = 1'b0;

    // Five load-use stalls plus a few flushes to exercise counter saturation.
    for (int i = 0; i < 5; i++) begin
      drive_cycle(LW, 1, 0, 3, 0, 0);
      drive_cycle(R, 1, 3, 1, 3, 0);
      drive_cycle(R, 1, 3, 1, 3, 0);
      drive_cycle(BEQ, 1, 0, 0, 0, 1);
    end
    wait_drained();
`ifdef CTRL_PERF_CNT_EN
    check("stall_cnt_saturated", stall_cnt, 3);
    check("flush_cnt_saturated", flush_cnt, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
